// File: rtl/fc2_spike_serializer_if.sv
// Spike-stream bus between the LIF1 producer, the serializer and the FC2_LIF2 receiver.
// Carries the parallel capture handshake and the serial address/data pair.
interface fc2_spike_serializer_if #(
  parameter int unsigned INPUT_NODES = 20
);
  logic [INPUT_NODES-1:0] spk_in;
  logic                   spk_in_valid;
  logic                   spk_in_ready;
  logic                   fc_addra_valid;
  logic                   input_fc_array;

  // Upstream producer / downstream observer side
  modport master (
    output spk_in,
    output spk_in_valid,
    input  spk_in_ready,
    input  fc_addra_valid,
    input  input_fc_array
  );

  // Serializer side
  modport slave (
    input  spk_in,
    input  spk_in_valid,
    output spk_in_ready,
    output fc_addra_valid,
    output input_fc_array
  );
endinterface

// File: rtl/fc2_spike_serializer.sv
// FC2 spike serializer: captures a parallel LIF1 spike vector and emits it one bit per
// cycle as an INPUT_NODES+1 slot frame on fc_addra_valid/input_fc_array, then idles for
// GAP_CYCLES so the receiver can drain. Optional SPK_TX_DBUF_EN adds a pending capture
// register so the next vector can be accepted while a frame is in flight.
module fc2_spike_serializer #(
  parameter int unsigned INPUT_NODES = 20,
  parameter int unsigned DATA_DLY    = 1,
  parameter int unsigned GAP_CYCLES  = 6,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fc2_spike_serializer_if.slave spk_bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int unsigned IDX_W = $clog2(INPUT_NODES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [GAP_W-1:0]       gap_cnt, gap_cnt_n;
  logic [INPUT_NODES-1:0] shadow, shadow_n;
  logic                   capture;
  logic                   last_gap;

  // Registered-output next values
  logic                   valid_d, bit_d, busy_d, done_d, ready_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   valid_q, ready_q;
  logic [DATA_DLY:0]      line;

`ifdef SPK_TX_DBUF_EN
  logic [INPUT_NODES-1:0] pending, pending_n;
  logic                   pend_valid, pend_valid_n;
`endif

  assign capture  = spk_bus.spk_in_valid && ready_q;
  assign last_gap = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  assign spk_bus.spk_in_ready   = ready_q;
  assign spk_bus.fc_addra_valid = valid_q;
  assign spk_bus.input_fc_array = line[DATA_DLY];

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      shadow     <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line       <= '0;
`ifdef SPK_TX_DBUF_EN
      pending    <= '0;
      pend_valid <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      gap_cnt    <= gap_cnt_n;
      shadow     <= shadow_n;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      busy       <= busy_d;
      frame_done <= done_d;
      frame_cnt  <= cnt_d;
      // Stage 0 is co-registered with valid; further stages model ROM read latency
      line[0]    <= bit_d;
      for (int unsigned i = 1; i <= DATA_DLY; i++) begin
        line[i] <= line[i-1];
      end
`ifdef SPK_TX_DBUF_EN
      pending    <= pending_n;
      pend_valid <= pend_valid_n;
`endif
    end
  end

  // Next-state: IDLE -> SEND -> GAP -> IDLE (or straight back to SEND when a vector waits)
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    gap_cnt_n = gap_cnt;
    shadow_n  = shadow;
`ifdef SPK_TX_DBUF_EN
    pending_n    = pending;
    pend_valid_n = pend_valid;
`endif
    case (state)
      IDLE: begin
        if (capture) begin
          state_n  = SEND;
          idx_n    = '0;
          shadow_n = spk_bus.spk_in;
        end
      end
      SEND: begin
        if (idx == IDX_W'(INPUT_NODES)) begin
          state_n   = GAP;
          gap_cnt_n = '0;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      GAP: begin
        if (last_gap) begin
`ifdef SPK_TX_DBUF_EN
          // A capture landing on the final gap cycle goes straight to shadow so it
          // cannot strand in pending while the FSM sits in IDLE.
          if (pend_valid) begin
            state_n      = SEND;
            idx_n        = '0;
            shadow_n     = pending;
            pend_valid_n = 1'b0;
          end else if (capture) begin
            state_n  = SEND;
            idx_n    = '0;
            shadow_n = spk_bus.spk_in;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef SPK_TX_DBUF_EN
    if (capture && (state != IDLE) && !last_gap) begin
      pending_n    = spk_bus.spk_in;
      pend_valid_n = 1'b1;
    end
`endif
  end

  // Output decode, registered one cycle behind the state
  always_comb begin
    valid_d = (state == SEND);
    bit_d   = (state == SEND) && (idx < IDX_W'(INPUT_NODES)) && shadow[idx];
    busy_d  = (state != IDLE);
    done_d  = last_gap;
    cnt_d   = last_gap ? frame_cnt + 1'b1 : frame_cnt;
`ifdef SPK_TX_DBUF_EN
    ready_d = !pend_valid_n;
`else
    ready_d = (state_n == IDLE);
`endif
  end

endmodule

// File: tb/tb_fc2_spike_serializer.sv
// Self-checking bench for fc2_spike_serializer. Two instances: the default configuration
// (DATA_DLY=1, CNT_W=16) and a DATA_DLY=0 / CNT_W=2 instance used for the wrap-slot and
// frame counter wrap scenarios.
module tb_fc2_spike_serializer;
  localparam int unsigned N = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic busy0, done0, busy1, done1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  fc2_spike_serializer_if #(.INPUT_NODES(N)) bus0 ();
  fc2_spike_serializer_if #(.INPUT_NODES(N)) bus1 ();

  fc2_spike_serializer #(.INPUT_NODES(N), .DATA_DLY(1), .GAP_CYCLES(6), .CNT_W(16)) dut (
    .clk(clk), .reset(rst0), .spk_bus(bus0), .busy(busy0), .frame_done(done0), .frame_cnt(cnt0)
  );

  fc2_spike_serializer #(.INPUT_NODES(N), .DATA_DLY(0), .GAP_CYCLES(6), .CNT_W(2)) dut_dly0 (
    .clk(clk), .reset(rst1), .spk_bus(bus1), .busy(busy1), .frame_done(done1), .frame_cnt(cnt1)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] exp_q0[$];
  logic [N-1:0] exp_q1[$];
  logic [15:0]  exp_cnt0;
  logic [1:0]   exp_cnt1;

  // Per-frame-cycle history
  logic vh[0:63], sh[0:63], dh[0:63], uh[0:63], rh[0:63];

  // Frame summary results
  logic [N-1:0] s_bits;
  int s_vcount, s_first, s_last, s_done_n, s_done_cnt, s_stray, s_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [N-1:0] v, input logic vld);
    if (sel == 0) begin
      bus0.spk_in = v; bus0.spk_in_valid = vld;
    end else begin
      bus1.spk_in = v; bus1.spk_in_valid = vld;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus0.spk_in_ready : bus1.spk_in_ready;
  endfunction

  // Presents v and waits for acceptance; returns one cycle after the capture edge
  task automatic send_vec(input int sel, input logic [N-1:0] v);
    int t = 0;
    drive(sel, v, 1'b1);
    while (!rdy(sel) && t < 200) begin
      tick();
      t++;
    end
    vectors++;
    if (t >= 200) begin
      miscompares++;
      $display("FAIL accept_timeout: ready=%0b required 1", rdy(sel));
      drive(sel, '0, 1'b0);
    end else begin
      tick();
      drive(sel, '0, 1'b0);
      if (sel == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
    end
  endtask

  // Records w frame cycles; optionally disturbs spk_in at frame cycle mod_n
  task automatic record(input int sel, input int w, input int mod_n);
    for (int n = 0; n < w; n++) begin
      tick();
      if (sel == 0) begin
        vh[n] = bus0.fc_addra_valid; sh[n] = bus0.input_fc_array;
        dh[n] = done0; uh[n] = busy0; rh[n] = bus0.spk_in_ready;
      end else begin
        vh[n] = bus1.fc_addra_valid; sh[n] = bus1.input_fc_array;
        dh[n] = done1; uh[n] = busy1; rh[n] = bus1.spk_in_ready;
      end
      if (mod_n >= 0 && n == mod_n)      drive(sel, 20'hFFFFF, 1'b1);
      if (mod_n >= 0 && n == mod_n + 12) drive(sel, '0, 1'b0);
    end
  endtask

  // Reduces history [off, off+w) to frame-relative statistics
  task automatic summarize(input int off, input int w, input int dly);
    s_bits = '0; s_vcount = 0; s_first = -1; s_last = -1;
    s_done_n = -1; s_done_cnt = 0; s_stray = 0; s_busy = 0;
    for (int m = 0; m < w; m++) begin
      if (vh[off+m]) begin
        s_vcount++;
        if (s_first < 0) s_first = m;
        s_last = m;
      end
      if (dh[off+m]) begin
        s_done_cnt++;
        if (s_done_n < 0) s_done_n = m;
      end
      if (uh[off+m]) s_busy++;
      if (m >= dly && m < dly + int'(N)) s_bits[m-dly] = sh[off+m];
      else if (sh[off+m]) s_stray++;
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, '0, 1'b0); drive(1, '0, 1'b0);
    tick(); tick();
    vectors++; if (bus0.spk_in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %0b required 0", bus0.spk_in_ready); end
    vectors++; if (bus0.fc_addra_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b required 0", bus0.fc_addra_valid); end
    vectors++; if (bus0.input_fc_array !== 1'b0) begin miscompares++; $display("FAIL rst_bit: got %0b required 0", bus0.input_fc_array); end
    vectors++; if ({busy0, done0} !== 2'b00) begin miscompares++; $display("FAIL rst_busy_done: got %0b required 00", {busy0, done0}); end
    vectors++; if (cnt0 !== 16'h0) begin miscompares++; $display("FAIL rst_cnt: got %0h required 0", cnt0); end
    vectors++; if ({bus1.spk_in_ready, bus1.fc_addra_valid, cnt1} !== 4'b0) begin miscompares++; $display("FAIL rst_dut1: got %0b required 0000", {bus1.spk_in_ready, bus1.fc_addra_valid, cnt1}); end
    rst0 = 1'b0; rst1 = 1'b0;
    exp_cnt0 = '0; exp_cnt1 = '0;
    tick();
    vectors++; if (bus0.spk_in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %0b required 1", bus0.spk_in_ready); end
    vectors++; if (bus1.spk_in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready1: got %0b required 1", bus1.spk_in_ready); end
  endtask

  task automatic test_single_frame();
    logic [N-1:0] e;
    send_vec(0, 20'h00001);
    record(0, 30, -1);
    summarize(0, 30, 1);
    e = exp_q0.pop_front();
    exp_cnt0 = exp_cnt0 + 1'b1;
    vectors++; if (s_bits !== e) begin miscompares++; $display("FAIL single_bits: got %05h required %05h", s_bits, e); end
    vectors++; if (sh[1] !== 1'b1) begin miscompares++; $display("FAIL single_cycle1: got %0b required 1", sh[1]); end
    vectors++; if (s_vcount !== 21) begin miscompares++; $display("FAIL single_vcount: got %0d required 21", s_vcount); end
    vectors++; if (s_first !== 0 || s_last !== 20) begin miscompares++; $display("FAIL single_vspan: got %0d..%0d required 0..20", s_first, s_last); end
    vectors++; if (s_done_n !== 26 || s_done_cnt !== 1) begin miscompares++; $display("FAIL single_done: got n=%0d cnt=%0d required n=26 cnt=1", s_done_n, s_done_cnt); end
    vectors++; if (s_stray !== 0) begin miscompares++; $display("FAIL single_stray: got %0d required 0", s_stray); end
    vectors++; if (s_busy !== 27) begin miscompares++; $display("FAIL single_busy: got %0d required 27", s_busy); end
    vectors++; if (cnt0 !== exp_cnt0) begin miscompares++; $display("FAIL single_cnt: got %0h required %0h", cnt0, exp_cnt0); end
  endtask

  task automatic test_dly0_wrap_slot();
    logic [N-1:0] e;
    send_vec(1, 20'h80000);
    record(1, 30, -1);
    summarize(0, 30, 0);
    e = exp_q1.pop_front();
    exp_cnt1 = exp_cnt1 + 1'b1;
    vectors++; if (s_bits !== e) begin miscompares++; $display("FAIL dly0_bits: got %05h required %05h", s_bits, e); end
    vectors++; if (sh[19] !== 1'b1) begin miscompares++; $display("FAIL dly0_cycle19: got %0b required 1", sh[19]); end
    vectors++; if (sh[20] !== 1'b0) begin miscompares++; $display("FAIL dly0_wrap_slot: got %0b required 0", sh[20]); end
    vectors++; if (s_stray !== 0) begin miscompares++; $display("FAIL dly0_stray: got %0d required 0", s_stray); end
    vectors++; if (s_vcount !== 21 || s_done_n !== 26) begin miscompares++; $display("FAIL dly0_timing: got v=%0d done=%0d required 21/26", s_vcount, s_done_n); end
    vectors++; if (cnt1 !== exp_cnt1) begin miscompares++; $display("FAIL dly0_cnt: got %0h required %0h", cnt1, exp_cnt1); end
  endtask

`ifdef SPK_TX_DBUF_EN
  task automatic test_back_to_back();
    logic [N-1:0] ea, eb;
    logic pre;
    int cap_n = -1;
    int rdy_low = 0;
    send_vec(0, 20'h00F0F);
    drive(0, 20'h30001, 1'b1);
    pre = rdy(0);
    for (int n = 0; n < 56; n++) begin
      tick();
      if (pre && bus0.spk_in_valid) begin
        cap_n = n;
        drive(0, '0, 1'b0);
        exp_q0.push_back(20'h30001);
      end
      vh[n] = bus0.fc_addra_valid; sh[n] = bus0.input_fc_array;
      dh[n] = done0; uh[n] = busy0; rh[n] = bus0.spk_in_ready;
      pre = rdy(0);
    end
    drive(0, '0, 1'b0);
    for (int n = 0; n < 26; n++) if (rh[n] === 1'b0) rdy_low++;
    vectors++; if (cap_n !== 0) begin miscompares++; $display("FAIL b2b_capture: got n=%0d required 0", cap_n); end
    vectors++; if (rdy_low !== 26 || rh[26] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got low=%0d r26=%0b required 26/1", rdy_low, rh[26]); end
    ea = exp_q0.pop_front();
    summarize(0, 27, 1);
    vectors++; if (s_bits !== ea || s_vcount !== 21 || s_done_n !== 26) begin miscompares++; $display("FAIL b2b_frame_a: got %05h v=%0d d=%0d required %05h 21 26", s_bits, s_vcount, s_done_n, ea); end
    if (exp_q0.size() > 0) eb = exp_q0.pop_front(); else eb = '0;
    summarize(27, 29, 1);
    vectors++; if (s_bits !== eb || s_first !== 0 || s_vcount !== 21 || s_done_n !== 26) begin miscompares++; $display("FAIL b2b_frame_b: got %05h f=%0d v=%0d d=%0d required %05h 0 21 26", s_bits, s_first, s_vcount, s_done_n, eb); end
    exp_cnt0 = exp_cnt0 + 16'd2;
    vectors++; if (cnt0 !== exp_cnt0) begin miscompares++; $display("FAIL b2b_cnt: got %0h required %0h", cnt0, exp_cnt0); end
  endtask
`else
  task automatic test_hold_no_capture();
    logic [N-1:0] e;
    int rdy_hi = 0;
    int late_v = 0;
    send_vec(0, 20'h0000F);
    record(0, 30, 5);
    summarize(0, 30, 1);
    e = exp_q0.pop_front();
    exp_cnt0 = exp_cnt0 + 1'b1;
    for (int n = 0; n < 26; n++) if (rh[n] !== 1'b0) rdy_hi++;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (bus0.fc_addra_valid !== 1'b0) late_v++;
    end
    vectors++; if (s_bits !== e) begin miscompares++; $display("FAIL hold_bits: got %05h required %05h", s_bits, e); end
    vectors++; if (rdy_hi !== 0) begin miscompares++; $display("FAIL hold_ready: got %0d ready cycles required 0", rdy_hi); end
    vectors++; if (late_v !== 0) begin miscompares++; $display("FAIL hold_no_capture: got %0d valid cycles required 0", late_v); end
    vectors++; if (cnt0 !== exp_cnt0) begin miscompares++; $display("FAIL hold_cnt: got %0h required %0h", cnt0, exp_cnt0); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [N-1:0] e;
    send_vec(0, 20'hFFFFF);
    for (int n = 0; n <= 10; n++) tick();
    vectors++; if (bus0.fc_addra_valid !== 1'b1 || bus0.input_fc_array !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got v=%0b b=%0b required 1/1", bus0.fc_addra_valid, bus0.input_fc_array); end
    rst0 = 1'b1;
    tick();
    vectors++; if ({bus0.fc_addra_valid, bus0.input_fc_array, busy0, done0} !== 4'b0) begin miscompares++; $display("FAIL mid_reset_outputs: got %0b required 0000", {bus0.fc_addra_valid, bus0.input_fc_array, busy0, done0}); end
    vectors++; if (cnt0 !== 16'h0) begin miscompares++; $display("FAIL mid_reset_cnt: got %0h required 0", cnt0); end
    void'(exp_q0.pop_front());
    exp_cnt0 = '0;
    rst0 = 1'b0;
    tick();
    send_vec(0, 20'h12345);
    record(0, 30, -1);
    summarize(0, 30, 1);
    e = exp_q0.pop_front();
    exp_cnt0 = exp_cnt0 + 1'b1;
    vectors++; if (s_bits !== e) begin miscompares++; $display("FAIL mid_after_bits: got %05h required %05h", s_bits, e); end
    vectors++; if (s_vcount !== 21 || s_first !== 0 || s_done_n !== 26) begin miscompares++; $display("FAIL mid_after_timing: got v=%0d f=%0d d=%0d required 21 0 26", s_vcount, s_first, s_done_n); end
    vectors++; if (cnt0 !== exp_cnt0) begin miscompares++; $display("FAIL mid_after_cnt: got %0h required %0h", cnt0, exp_cnt0); end
  endtask

  task automatic test_cnt_wrap();
    logic [N-1:0] vecs[3];
    logic [N-1:0] e;
    vecs[0] = 20'h00000; vecs[1] = 20'h5A5A5; vecs[2] = 20'h00001;
    for (int i = 0; i < 3; i++) begin
      send_vec(1, vecs[i]);
      record(1, 30, -1);
      summarize(0, 30, 0);
      e = exp_q1.pop_front();
      exp_cnt1 = exp_cnt1 + 1'b1;
      vectors++; if (s_bits !== e || s_stray !== 0) begin miscompares++; $display("FAIL wrap_bits[%0d]: got %05h stray=%0d required %05h 0", i, s_bits, s_stray, e); end
      vectors++; if (s_done_cnt !== 1) begin miscompares++; $display("FAIL wrap_done[%0d]: got %0d pulses required 1", i, s_done_cnt); end
      vectors++; if (cnt1 !== exp_cnt1) begin miscompares++; $display("FAIL wrap_cnt[%0d]: got %0h required %0h", i, cnt1, exp_cnt1); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_dly0_wrap_slot();
`ifdef SPK_TX_DBUF_EN
    test_back_to_back();
`else
    test_hold_no_capture();
`endif
    test_reset_mid_frame();
    test_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
